// File: rtl/tick_timer_arbiter.sv
// Round-robin arbiter sharing one prescaled countdown timer among NREQ requesters.
// The owner holds req high for len ticks of PRESCALE clk_in cycles and then receives a done pulse.
module tick_timer_arbiter #(
  parameter int NREQ     = 4,
  parameter int PRESCALE = 100000000,
  parameter int CNT_W    = 16
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*CNT_W-1:0]    len,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  cur_id,
  output logic                     tick
);

  localparam int ID_W = $clog2(NREQ);
  localparam int PS_W = $clog2(PRESCALE);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(PRESCALE - 1);
  localparam logic [NREQ-1:0]  ONE_HOT = NREQ'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [PS_W-1:0]  pscnt;
  logic [CNT_W-1:0] remaining;
  logic [ID_W-1:0]  last;

  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  cand;
  logic             found;
  int unsigned      idx;
  logic [CNT_W-1:0] win_len;
  logic             owner_req;

  // Search starts just after the previous owner, so the last owner has lowest priority.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx  = (32'(last) + i) % NREQ;
      cand = ID_W'(idx);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign win_len   = len[winner*CNT_W +: CNT_W];
  assign owner_req = req[cur_id];
  assign tick      = (state == COUNT) && (pscnt == PS_MAX);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      cur_id    <= '0;
      pscnt     <= '0;
      remaining <= '0;
      last      <= ID_W'(NREQ - 1);
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state     <= LOAD;
            grant     <= ONE_HOT << winner;
            cur_id    <= winner;
            remaining <= win_len;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (!owner_req) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            last      <= cur_id;
            remaining <= '0;
          end else if (remaining == '0) begin
            state <= DONE;
            done  <= ONE_HOT << cur_id;
          end else begin
            state <= COUNT;
            pscnt <= '0;
          end
        end
        COUNT: begin
          // Abort takes precedence over a completion tick in the same cycle.
          if (!owner_req) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            last      <= cur_id;
            pscnt     <= '0;
            remaining <= '0;
          end else begin
            pscnt <= (pscnt == PS_MAX) ? '0 : pscnt + 1'b1;
            if (tick) begin
              remaining <= remaining - 1'b1;
              if (remaining == CNT_ONE) begin
                state <= DONE;
                done  <= ONE_HOT << cur_id;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
          last  <= cur_id;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Scoreboard bench for tick_timer_arbiter: directed stimulus queues expected grant/done/release
// events, and a negedge monitor pops and compares them as the DUT produces them.
module tb_tick_timer_arbiter;

  localparam int NREQ     = 4;
  localparam int PRESCALE = 4;
  localparam int CNT_W    = 8;

  localparam int K_GRANT = 0;
  localparam int K_DONE  = 1;
  localparam int K_END   = 2;

  logic                    clk_in = 1'b0;
  logic                    reset;
  logic [NREQ-1:0]         req;
  logic [NREQ*CNT_W-1:0]   len;
  logic [NREQ-1:0]         grant;
  logic [NREQ-1:0]         done;
  logic                    busy;
  logic [1:0]              cur_id;
  logic                    tick;

  typedef struct {
    int kind;
    int val;
    int id;
    int delta;
    int ticks;
  } exp_t;

  exp_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;

  logic            mon_en = 1'b0;
  logic [NREQ-1:0] prev_grant;
  int              cyc = 0;
  int              rise_cyc = 0;
  int              fall_cyc = 0;
  int              last_tick = 0;
  int              nticks = 0;
  int              exp_id = 0;

  tick_timer_arbiter #(
    .NREQ(NREQ),
    .PRESCALE(PRESCALE),
    .CNT_W(CNT_W)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .req(req),
    .len(len),
    .grant(grant),
    .done(done),
    .busy(busy),
    .cur_id(cur_id),
    .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic pop_exp(input int kind, output exp_t e);
    if (exp_q.size() == 0) begin
      chk("unexpected_event", kind, -1);
      e = '{kind: -1, val: -1, id: -1, delta: -1, ticks: -1};
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
    end
  endtask

  task automatic push(input int kind, input int val, input int id, input int delta, input int ticks);
    exp_t e;
    e = '{kind: kind, val: val, id: id, delta: delta, ticks: ticks};
    exp_q.push_back(e);
  endtask

  // Expected event triple for one completed service of requester id.
  task automatic push_service(input int id, input int gap, input int tl);
    push(K_GRANT, 1 << id, id, gap, 0);
    push(K_DONE, 1 << id, id, 1 + tl * PRESCALE, 0);
    push(K_END, 0, id, 2 + tl * PRESCALE, tl);
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    cyc++;
    if (!mon_en || reset) begin
      prev_grant = '0;
    end else begin
      if (grant != prev_grant) begin
        if (prev_grant != '0) begin
          pop_exp(K_END, e);
          chk("grant_length", cyc - rise_cyc, e.delta);
          chk("tick_count", nticks, e.ticks);
          fall_cyc = cyc;
        end
        if (grant != '0) begin
          pop_exp(K_GRANT, e);
          chk("grant_value", int'(grant), e.val);
          chk("grant_cur_id", int'(cur_id), e.id);
          if (e.delta >= 0) chk("idle_gap", cyc - fall_cyc, e.delta);
          rise_cyc = cyc;
          nticks   = 0;
          exp_id   = e.id;
        end
        prev_grant = grant;
      end
      if (grant != '0) begin
        chk("cur_id_stable", int'(cur_id), exp_id);
        chk("busy_with_grant", int'(busy), 1);
      end
      if (tick) begin
        if (nticks > 0) chk("tick_spacing", cyc - last_tick, PRESCALE);
        nticks++;
        last_tick = cyc;
      end
      if (done != '0) begin
        pop_exp(K_DONE, e);
        chk("done_value", int'(done), e.val);
        chk("done_delay", cyc - rise_cyc, e.delta);
      end
    end
  end

  task automatic wait_done(input int idx, input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk_in);
      if (done[idx]) break;
    end
    if (n == budget) chk("done_timeout", idx, -1);
  endtask

  task automatic wait_grant(input int idx, input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk_in);
      if (grant[idx]) break;
    end
    if (n == budget) chk("grant_timeout", idx, -1);
  endtask

  initial begin
    #20000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b0;
    req   = '0;
    len   = '0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("reset_grant", int'(grant), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cur_id", int'(cur_id), 0);
    chk("reset_tick", int'(tick), 0);
    mon_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk_in);

    // Single request, len0=3; len0 rewritten mid-count must not alter the delay.
    push_service(0, -1, 3);
    req = 4'b0001;
    len[0*CNT_W +: CNT_W] = 8'd3;
    repeat (5) @(negedge clk_in);
    len[0*CNT_W +: CNT_W] = 8'd9;
    wait_done(0, 60);
    req = '0;
    repeat (2) @(negedge clk_in);

    // Zero length on requester 2.
    push_service(2, -1, 0);
    req = 4'b0100;
    len[2*CNT_W +: CNT_W] = 8'd0;
    wait_done(2, 20);
    req = '0;
    repeat (2) @(negedge clk_in);

    // Abort requester 1 after 7 cycles while requester 3 waits.
    push(K_GRANT, 4'b0010, 1, -1, 0);
    push(K_END, 0, 1, 8, 1);
    push_service(3, 1, 2);
    req = 4'b0010;
    len[1*CNT_W +: CNT_W] = 8'd5;
    wait_grant(1, 20);
    req[3] = 1'b1;
    len[3*CNT_W +: CNT_W] = 8'd2;
    repeat (7) @(negedge clk_in);
    req[1] = 1'b0;
    wait_done(3, 60);
    req = '0;
    repeat (3) @(negedge clk_in);

    // Asynchronous reset mid-count, then fairness with all requesters held.
    mon_en = 1'b0;
    req = 4'b0001;
    len[0*CNT_W +: CNT_W] = 8'd3;
    repeat (6) @(negedge clk_in);
    chk("pre_reset_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_grant", int'(grant), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_done", int'(done), 0);
    chk("async_reset_cur_id", int'(cur_id), 0);
    chk("async_reset_tick", int'(tick), 0);
    @(negedge clk_in);
    mon_en = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) len[i*CNT_W +: CNT_W] = 8'd1;
    for (int k = 0; k < 5; k++) push_service(k % NREQ, (k == 0) ? -1 : 1, 1);
    @(negedge clk_in);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) wait_done(k % NREQ, 30);
    req = '0;
    repeat (5) @(negedge clk_in);

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_busy", int'(busy), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
